mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 9, memory address width in bits.
REQ-002 Parameter DW, default 16, memory data width in bits.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port cpu_req / cpu_write  input  1 each  CPU access request; 1 = write, 0 = read.
REQ-006 Port cpu_addr  input  AW, and port cpu_wdata  input  DW: CPU address and write data.
REQ-007 Port cpu_gnt / cpu_rvalid  output  1 each: CPU access granted; CPU read data valid.
REQ-008 Port cpu_rdata  output  DW  CPU read data.
REQ-009 Ports dbg_req, dbg_write, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata SHALL mirror the CPU ports for the debug/loader requester.
REQ-010 Port mem_cmd  output  2  memory command: 00 = NONE, 01 = READ, 10 = WRITE.
REQ-011 Ports mem_addr (output, AW) and mem_wdata (output, DW): memory address and write data.
REQ-012 Port mem_rdata  input  DW  memory read data, valid one cycle after a READ command.
REQ-013 Port busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, CPU_ACC, DBG_ACC, RD_RET.
REQ-015 In IDLE, if any req is high: register the winner, move to CPU_ACC or DBG_ACC, and assert the winner's gnt in the next cycle.
REQ-016 In CPU_ACC/DBG_ACC (exactly one cycle):
- mem_cmd, mem_addr and mem_wdata come combinationally from the owner's inputs.
- Only the owner's gnt is high.
- Next state is RD_RET for a read, IDLE for a write.
REQ-017 In RD_RET: owner's rvalid = 1 and owner's rdata = mem_rdata; mem_cmd = NONE; next state IDLE.
REQ-018 Latency: req sampled in cycle N gives gnt in N+1 and, for a read, rvalid in N+2; next arbitration in N+2 (write) or N+3 (read).
REQ-019 Requesters hold req, write, addr and wdata stable until gnt; they drop req on the edge ending the gnt cycle.
REQ-020 Arbitration defaults to round-robin: on simultaneous requests the requester that was not the last owner wins.
REQ-021 The non-owner's gnt and rvalid stay 0; its rdata is don't-care; its pending req is held, not lost.
REQ-022 In IDLE with no req: mem_cmd = NONE and busy = 0.
REQ-023 A req that rises during an access is serviced at the next IDLE evaluation.
REQ-024 The arbiter passes all addresses through unchecked; addr wrap is the memory's concern.

Reset
REQ-025 When reset_n = 0, immediately:
- state = IDLE; last owner = DBG, so the CPU wins first.
- All gnt and rvalid = 0; mem_cmd = NONE; busy = 0.
REQ-026 Reset during CPU_ACC, DBG_ACC or RD_RET aborts the access; no rvalid is produced after reset is released.
REQ-027 After release, arbitration begins on the first rising edge with reset_n = 1.

Configuration
REQ-028 Macro MEM_ARB_FIXED_PRIO_EN defined: the CPU always wins simultaneous requests, and the DBG requester is served only when cpu_req = 0 in IDLE.
REQ-029 Macro MEM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-020.

Verification
REQ-030 After reset, cpu_req read at addr 0x005, memory holding 0xABCD there -> cpu_gnt at N+1 with mem_cmd = 01 and mem_addr = 0x005; cpu_rvalid and cpu_rdata = 0xABCD at N+2.
REQ-031 dbg write 0x1234 to 0x006 -> dbg_gnt at N+1 with mem_cmd = 10 and mem_wdata = 0x1234; busy = 0 at N+2; a later read of 0x006 returns 0x1234.
REQ-032 Both requesting continuous reads, round-robin build -> grant order CPU, DBG, CPU, DBG, with no cycle where both gnt are high.
REQ-033 Same stimulus with MEM_ARB_FIXED_PRIO_EN -> CPU granted every access; dbg_gnt stays 0 until cpu_req drops.
REQ-034 reset_n pulsed low during RD_RET of a CPU read -> cpu_rvalid = 0 immediately and after release; mem_cmd = 00; first post-reset grant goes to the CPU.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / debug-loader) arbiter in front of a single-port memory.
// Define MEM_ARB_FIXED_PRIO_EN for fixed CPU priority; the default build is round-robin.
module mem_arbiter #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,

  input  logic          cpu_req,
  input  logic          cpu_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,

  input  logic          dbg_req,
  input  logic          dbg_write,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,

  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CPU_ACC = 2'b01,
    DBG_ACC = 2'b10,
    RD_RET  = 2'b11
  } state_t;

  state_t state_q, state_d;
  // Owner of the access in flight; only consulted in RD_RET.
  logic   owner_dbg_q, owner_dbg_d;
  logic   win_dbg;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic   last_dbg_q, last_dbg_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_dbg_q <= 1'b1;
    end else begin
      last_dbg_q <= last_dbg_d;
    end
  end

  // Round-robin: on a tie the requester that did not own the memory last wins.
  always_comb begin
    last_dbg_d = last_dbg_q;
    if (cpu_req && dbg_req) begin
      win_dbg = !last_dbg_q;
    end else begin
      win_dbg = dbg_req;
    end
    if (state_q == IDLE && (cpu_req || dbg_req)) begin
      last_dbg_d = win_dbg;
    end
  end
`else
  // Fixed priority: debug is only served when the CPU is not asking.
  always_comb begin
    win_dbg = !cpu_req;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_dbg_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      owner_dbg_q <= owner_dbg_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_dbg_d = owner_dbg_q;
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    cpu_rvalid  = 1'b0;
    dbg_rvalid  = 1'b0;
    cpu_rdata   = '0;
    dbg_rdata   = '0;
    mem_cmd     = CMD_NONE;
    mem_addr    = '0;
    mem_wdata   = '0;
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_dbg_d = win_dbg;
          state_d     = win_dbg ? DBG_ACC : CPU_ACC;
        end
      end
      // Command fields come straight from the owner, which holds them until gnt.
      CPU_ACC: begin
        cpu_gnt   = 1'b1;
        mem_cmd   = cpu_write ? CMD_WRITE : CMD_READ;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        state_d   = cpu_write ? IDLE : RD_RET;
      end
      DBG_ACC: begin
        dbg_gnt   = 1'b1;
        mem_cmd   = dbg_write ? CMD_WRITE : CMD_READ;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        state_d   = dbg_write ? IDLE : RD_RET;
      end
      RD_RET: begin
        if (owner_dbg_q) begin
          dbg_rvalid = 1'b1;
          dbg_rdata  = mem_rdata;
        end else begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = mem_rdata;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level schedule model plus a behavioural memory.
module tb_mem_arbiter;
  localparam int AW   = 9;
  localparam int DW   = 16;
  localparam int MAXC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          cpu_req, cpu_write, dbg_req, dbg_write;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata;
  logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, busy;
  logic [DW-1:0] cpu_rdata, dbg_rdata;
  logic [1:0]    mem_cmd;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_write(dbg_write), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Behavioural single-port memory: read data appears one cycle after READ.
  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 5) return 16'hABCD;
    return DW'((a * 40503) ^ 23130);
  endfunction

  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit            mem_init;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_cmd == 2'b01) begin
      mem_rdata <= mem[mem_addr];
    end else if (mem_cmd == 2'b10) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Expected per-cycle outputs, filled in when an arbitration is predicted.
  typedef struct {
    bit          cg, dg, cv, dv, busy;
    bit [1:0]    cmd;
    bit [AW-1:0] addr;
    bit [DW-1:0] wdata, rdata;
  } exp_t;
  typedef struct {
    bit          wr;
    bit [AW-1:0] addr;
    bit [DW-1:0] wdata;
  } txn_t;

  exp_t          ex [MAXC];
  exp_t          empty_e;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            next_free;
  bit            m_last_dbg;
  txn_t          cq[$], dq[$];
  bit            c_pend, d_pend;
  int            glog[$];
  logic [DW-1:0] last_crd, last_drd;
  int            cyc;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic txn_t mk(input bit wr, input int a, input int d);
    txn_t t;
    t.wr = wr; t.addr = AW'(a); t.wdata = DW'(d);
    return t;
  endfunction

  // Predict the outcome of the IDLE evaluation at rising edge p from the request rules.
  task automatic model_arb(input int p);
    bit          wd, wr;
    bit [AW-1:0] a;
    bit [DW-1:0] d;
    if (p < next_free || !(cpu_req || dbg_req)) return;
`ifdef MEM_ARB_FIXED_PRIO_EN
    wd = !cpu_req;
`else
    wd = (cpu_req && dbg_req) ? !m_last_dbg : dbg_req;
`endif
    wr = wd ? dbg_write : cpu_write;
    a  = wd ? dbg_addr  : cpu_addr;
    d  = wd ? dbg_wdata : cpu_wdata;
    ex[p].busy = 1'b1; ex[p].cg = !wd; ex[p].dg = wd;
    ex[p].cmd = wr ? 2'b10 : 2'b01; ex[p].addr = a; ex[p].wdata = d;
    if (wr) begin
      ref_mem[a] = d;
      next_free  = p + 2;
    end else begin
      ex[p+1].busy = 1'b1;
      if (wd) ex[p+1].dv = 1'b1; else ex[p+1].cv = 1'b1;
      ex[p+1].rdata = ref_mem[a];
      next_free = p + 3;
    end
    m_last_dbg = wd;
  endtask

  task automatic step();
    exp_t e;
    txn_t t;
    @(negedge clk);
    cyc++;
    if (cyc >= MAXC - 4) begin
      $display("FAIL cycle_budget cyc=%0d got=%0d want<%0d", cyc, cyc, MAXC - 4);
      $fatal(1, "cycle budget exhausted");
    end
    e = ex[cyc];
    check("cpu_gnt", cpu_gnt, e.cg);
    check("dbg_gnt", dbg_gnt, e.dg);
    check("cpu_rvalid", cpu_rvalid, e.cv);
    check("dbg_rvalid", dbg_rvalid, e.dv);
    check("busy", busy, e.busy);
    check("mem_cmd", mem_cmd, e.cmd);
    check("gnt_excl", cpu_gnt & dbg_gnt, 0);
    if (e.cg || e.dg) begin
      check("mem_addr", mem_addr, e.addr);
      if (e.cmd == 2'b10) check("mem_wdata", mem_wdata, e.wdata);
    end
    if (e.cv) check("cpu_rdata", cpu_rdata, e.rdata);
    if (e.dv) check("dbg_rdata", dbg_rdata, e.rdata);
    if (cpu_rvalid === 1'b1) last_crd = cpu_rdata;
    if (dbg_rvalid === 1'b1) last_drd = dbg_rdata;
    if (cpu_gnt === 1'b1) glog.push_back(0);
    if (dbg_gnt === 1'b1) glog.push_back(1);
    // Requesters drop req once granted and may start a new one a cycle later.
    if (c_pend && cpu_gnt === 1'b1) begin
      c_pend = 1'b0; cpu_req = 1'b0;
    end else if (!c_pend && cq.size() > 0) begin
      t = cq.pop_front();
      cpu_req = 1'b1; cpu_write = t.wr; cpu_addr = t.addr; cpu_wdata = t.wdata; c_pend = 1'b1;
    end
    if (d_pend && dbg_gnt === 1'b1) begin
      d_pend = 1'b0; dbg_req = 1'b0;
    end else if (!d_pend && dq.size() > 0) begin
      t = dq.pop_front();
      dbg_req = 1'b1; dbg_write = t.wr; dbg_addr = t.addr; dbg_wdata = t.wdata; d_pend = 1'b1;
    end
    model_arb(cyc + 1);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((cq.size() > 0 || dq.size() > 0 || c_pend || d_pend || cyc < next_free) && n < max) begin
      step();
      n++;
    end
    if (n >= max) check("drain_timeout", n, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_cpu_rvalid"}, cpu_rvalid, 0);
    check({tag, "_dbg_rvalid"}, dbg_rvalid, 0);
    check({tag, "_gnt"}, {cpu_gnt, dbg_gnt}, 0);
    check({tag, "_mem_cmd"}, mem_cmd, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int exp_order [8];
    int n;
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_write = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < MAXC; i++) ex[i] = empty_e;
    c_pend = 1'b0; d_pend = 1'b0; cyc = 0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset_n = 1'b1; next_free = 1; m_last_dbg = 1'b1;

    // Directed CPU read of the preloaded word.
    cq.push_back(mk(0, 5, 0));
    drain(50);
    check("cpu_read_0x005", last_crd, 16'hABCD);

    // Debug write then read-back.
    dq.push_back(mk(1, 6, 16'h1234));
    dq.push_back(mk(0, 6, 0));
    drain(50);
    check("dbg_readback_0x006", last_drd, 16'h1234);

    // Both requesting back-to-back reads.
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      cq.push_back(mk(0, 16 + i, 0));
      dq.push_back(mk(0, 32 + i, 0));
    end
    drain(200);
    for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_order[i] = (i < 4) ? 0 : 1;
`else
      exp_order[i] = i % 2;
`endif
    end
    check("order_len", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++) check("grant_order", glog[i], exp_order[i]);

    // Reset pulse during the read-return cycle of a CPU read.
    cq.push_back(mk(0, 7, 0));
    n = 0;
    while (cpu_rvalid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("rd_ret_reached", cpu_rvalid, 1);
    #1 reset_n = 1'b0;
    #1 check_quiet("async_rst");
    cpu_req = 1'b0; dbg_req = 1'b0; c_pend = 1'b0; d_pend = 1'b0;
    cq.delete(); dq.delete();
    for (int i = cyc + 1; i < MAXC; i++) ex[i] = empty_e;
    m_last_dbg = 1'b1;
    @(negedge clk);
    cyc++;
    check_quiet("in_rst");
    reset_n = 1'b1;
    next_free = cyc + 1;
    glog.delete();
    dq.push_back(mk(0, 8, 0));
    cq.push_back(mk(0, 9, 0));
    drain(50);
    check("post_rst_first_owner", (glog.size() > 0) ? glog[0] : 2, 0);

    // Random mixed traffic on a small address window so reads hit prior writes.
    for (int i = 0; i < 700; i++) begin
      if (cq.size() < 2 && $urandom_range(0, 99) < 40)
        cq.push_back(mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom));
      if (dq.size() < 2 && $urandom_range(0, 99) < 40)
        dq.push_back(mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom));
      step();
    end
    drain(100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
